// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake, control bundle and status signals between the multi-cycle
// sequencer and the memory/datapath side.
interface multicycle_control_fsm_if #(
    parameter int unsigned RETIRE_W = 32
) ();
    logic [31:0]         instr;
    logic                mem_ready;
    logic [3:0]          ALU_Control;
    logic [2:0]          ImmSel;
    logic [1:0]          MemtoReg;
    logic                ALUSrc_B;
    logic                Jump;
    logic                Branch;
    logic                InverseBranch;
    logic                PCOffset;
    logic                RegWrite;
    logic                ir_write;
    logic                pc_write;
    logic                mem_req;
    logic                mem_we;
    logic                illegal_insn;
    logic [RETIRE_W-1:0] retired_count;

    modport master (
        input  instr, mem_ready,
        output ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch, InverseBranch, PCOffset,
        output RegWrite, ir_write, pc_write, mem_req, mem_we, illegal_insn, retired_count
    );

    modport slave (
        output instr, mem_ready,
        input  ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch, InverseBranch, PCOffset,
        input  RegWrite, ir_write, pc_write, mem_req, mem_we, illegal_insn, retired_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with a control
// bundle registered once per instruction in DECODE.
module multicycle_control_fsm #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StIllegal} state_e;
    typedef enum logic [1:0] {ClsAlu, ClsBranch, ClsLoad, ClsStore} cls_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e              state_q, state_d;
    cls_e                cls_q, cls_d;
    logic                run_q;
    logic [3:0]          alu_q, alu_d;
    logic [2:0]          imm_q, imm_d;
    logic [1:0]          m2r_q, m2r_d;
    logic                srcb_q, srcb_d, jump_q, jump_d, branch_q, branch_d;
    logic                inv_q, inv_d, pcoff_q, pcoff_d;
    logic                legal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                ir_write, pc_write, mem_req, mem_we, reg_write;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr;
    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign alt          = bus.instr[30];
    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // SUB only exists for register-register ops; SRA/SRAI share bit 30.
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic a, input logic is_reg);
        logic [3:0] r;
        unique case (f3)
            3'b000:  r = (a && is_reg) ? 4'd1 : 4'd0;
            3'b001:  r = 4'd5;
            3'b010:  r = 4'd8;
            3'b011:  r = 4'd9;
            3'b100:  r = 4'd4;
            3'b101:  r = a ? 4'd7 : 4'd6;
            3'b110:  r = 4'd3;
            default: r = 4'd2;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_d    = 4'd0;
        imm_d    = 3'd0;
        m2r_d    = 2'd0;
        srcb_d   = 1'b0;
        jump_d   = 1'b0;
        branch_d = 1'b0;
        inv_d    = 1'b0;
        pcoff_d  = 1'b0;
        cls_d    = ClsAlu;
        legal_d  = 1'b1;
        unique case (opcode)
            OpReg: alu_d = alu_sel(funct3, alt, 1'b1);
            OpImm: begin
                alu_d  = alu_sel(funct3, alt, 1'b0);
                srcb_d = 1'b1;
            end
            OpLoad: begin
                srcb_d = 1'b1;
                m2r_d  = 2'd1;
                cls_d  = ClsLoad;
            end
            OpStore: begin
                srcb_d = 1'b1;
                imm_d  = 3'd1;
                cls_d  = ClsStore;
            end
            OpBranch: begin
                alu_d    = 4'd1;
                imm_d    = 3'd2;
                branch_d = 1'b1;
                inv_d    = (funct3 == 3'b001);
                cls_d    = ClsBranch;
            end
            OpJal: begin
                imm_d  = 3'd3;
                m2r_d  = 2'd2;
                jump_d = 1'b1;
            end
            OpJalr: begin
                srcb_d  = 1'b1;
                m2r_d   = 2'd2;
                jump_d  = 1'b1;
                pcoff_d = 1'b1;
            end
            OpLui: begin
                imm_d = 3'd4;
                m2r_d = 2'd3;
            end
            OpAuipc: begin
                imm_d  = 3'd4;
                srcb_d = 1'b1;
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        unique case (state_q)
            StFetch: begin
                // run_q holds off the first request until one full cycle after reset release.
                if (run_q) begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = StDecode;
                    end
                end
            end
            StDecode: state_d = legal_d ? StExec : StIllegal;
            StExec: begin
                unique case (cls_q)
                    ClsBranch: begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == ClsStore);
                if (bus.mem_ready) begin
                    if (cls_q == ClsStore) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StIllegal;
        endcase
    end

    assign retired_d = pc_write ? retired_q + RETIRE_W'(1) : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            run_q     <= 1'b0;
            cls_q     <= ClsAlu;
            alu_q     <= 4'd0;
            imm_q     <= 3'd0;
            m2r_q     <= 2'd0;
            srcb_q    <= 1'b0;
            jump_q    <= 1'b0;
            branch_q  <= 1'b0;
            inv_q     <= 1'b0;
            pcoff_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            retired_q <= retired_d;
            if (state_q == StDecode) begin
                cls_q    <= cls_d;
                alu_q    <= alu_d;
                imm_q    <= imm_d;
                m2r_q    <= m2r_d;
                srcb_q   <= srcb_d;
                jump_q   <= jump_d;
                branch_q <= branch_d;
                inv_q    <= inv_d;
                pcoff_q  <= pcoff_d;
            end
        end
    end

    assign bus.ALU_Control   = alu_q;
    assign bus.ImmSel        = imm_q;
    assign bus.MemtoReg      = m2r_q;
    assign bus.ALUSrc_B      = srcb_q;
    assign bus.Jump          = jump_q;
    assign bus.Branch        = branch_q;
    assign bus.InverseBranch = inv_q;
    assign bus.PCOffset      = pcoff_q;
    assign bus.RegWrite      = reg_write;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.mem_req       = mem_req;
    assign bus.mem_we        = mem_we;
    assign bus.illegal_insn  = (state_q == StIllegal);
    assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, random instruction stream
// against a transaction-level timing model, and reset/illegal/wrap corner cases.
module tb_multicycle_control_fsm;
    typedef struct packed {
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] m2r;
        logic       srcb;
        logic       jump;
        logic       branch;
        logic       inv;
        logic       pcoff;
    } fields_t;

    // cls: 0 branch, 1 writeback-only, 2 load, 3 store
    typedef struct {
        logic [31:0] ins;
        int          fw;
        int          mw;
        int          cls;
        fields_t     f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_cnt = '0;
    fields_t     prev_f = '0;

    multicycle_control_fsm_if #(.RETIRE_W(32)) ifc32 ();
    multicycle_control_fsm_if #(.RETIRE_W(4))  ifc4 ();

    assign ifc4.instr     = ifc32.instr;
    assign ifc4.mem_ready = ifc32.mem_ready;

    multicycle_control_fsm #(.RETIRE_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(ifc32));
    multicycle_control_fsm #(.RETIRE_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc4));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    function automatic fields_t mkf(input int alu, input int imm, input int m2r, input bit srcb,
                                    input bit jump, input bit branch, input bit inv, input bit pcoff);
        fields_t f;
        f.alu = 4'(alu);
        f.imm = 3'(imm);
        f.m2r = 2'(m2r);
        f.srcb = srcb;
        f.jump = jump;
        f.branch = branch;
        f.inv = inv;
        f.pcoff = pcoff;
        return f;
    endfunction

    function automatic logic [5:0] en32();
        return {ifc32.mem_req, ifc32.mem_we, ifc32.ir_write, ifc32.pc_write, ifc32.RegWrite,
                ifc32.illegal_insn};
    endfunction

    function automatic logic [5:0] en4();
        return {ifc4.mem_req, ifc4.mem_we, ifc4.ir_write, ifc4.pc_write, ifc4.RegWrite,
                ifc4.illegal_insn};
    endfunction

    function automatic fields_t fl32();
        return {ifc32.ALU_Control, ifc32.ImmSel, ifc32.MemtoReg, ifc32.ALUSrc_B, ifc32.Jump,
                ifc32.Branch, ifc32.InverseBranch, ifc32.PCOffset};
    endfunction

    function automatic fields_t fl4();
        return {ifc4.ALU_Control, ifc4.ImmSel, ifc4.MemtoReg, ifc4.ALUSrc_B, ifc4.Jump,
                ifc4.Branch, ifc4.InverseBranch, ifc4.PCOffset};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // exp_en order: {mem_req, mem_we, ir_write, pc_write, RegWrite, illegal_insn}
    task automatic check_cycle(input string tag, input logic [5:0] exp_en, input bit do_f,
                               input fields_t exp_f);
        chk({tag, "_en32"}, 64'(en32()), 64'(exp_en));
        chk({tag, "_en4"}, 64'(en4()), 64'(exp_en));
        if (do_f) begin
            chk({tag, "_fields32"}, 64'(fl32()), 64'(exp_f));
            chk({tag, "_fields4"}, 64'(fl4()), 64'(exp_f));
        end
        chk({tag, "_cnt32"}, 64'(ifc32.retired_count), 64'(model_cnt));
        chk({tag, "_cnt4"}, 64'(ifc4.retired_count), 64'(model_cnt[3:0]));
    endtask

    // Assert reset now, hold three cycles with mem_ready high, release on a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        ifc32.mem_ready = 1'b1;
        #1;
        model_cnt = '0;
        prev_f = '0;
        check_cycle("reset_now", 6'b000000, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc32.mem_ready = 1'b1;
            #1;
            check_cycle("reset_hold", 6'b000000, 1'b1, '0);
        end
        @(negedge clk);
        ifc32.mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    // Timeline model: fetch (fw waits), decode, exec, optional mem (mw waits), optional wb.
    task automatic run_insn(input logic [31:0] ins, input int fw, input int mw, input int cls,
                            input fields_t f);
        int  len;
        bit  in_fetch, in_mem, last;
        logic [5:0] exp;
        case (cls)
            0:       len = fw + 3;
            1:       len = fw + 4;
            3:       len = fw + 4 + mw;
            default: len = fw + 5 + mw;
        endcase
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            in_fetch = (k <= fw);
            in_mem   = (cls >= 2) && (k >= fw + 3) && (k <= fw + 3 + mw);
            last     = (k == len - 1);
            if (in_fetch) ifc32.mem_ready = (k == fw);
            else if (in_mem) ifc32.mem_ready = (k == fw + 3 + mw);
            else ifc32.mem_ready = 1'($urandom);
            ifc32.instr = (k > fw) ? ins : $urandom;
            exp = {in_fetch || in_mem, in_mem && (cls == 3), in_fetch && (k == fw), last,
                   last && (cls == 1 || cls == 2), 1'b0};
            #1;
            check_cycle("insn", exp, 1'b1, (k >= fw + 2) ? f : prev_f);
        end
        prev_f = f;
        model_cnt = model_cnt + 1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  ops [9];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r = $urandom;
        r[6:0] = ops[$urandom_range(8, 0)];
        if (r[6:0] == 7'h63) r[14:13] = 2'b00;
        return r;
    endfunction

    // Reference decode from the instruction set's mnemonic rules.
    task automatic ref_decode(input logic [31:0] ins, output int cls, output fields_t f);
        logic [3:0] by_f3 [8];
        logic [2:0] f3;
        by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        f3 = ins[14:12];
        f = '0;
        cls = 1;
        case (ins[6:0])
            7'h33: begin
                f.alu = by_f3[f3];
                if (ins[30] && f3 == 3'd0) f.alu = 4'd1;
                if (ins[30] && f3 == 3'd5) f.alu = 4'd7;
            end
            7'h13: begin
                f.alu = by_f3[f3];
                if (ins[30] && f3 == 3'd5) f.alu = 4'd7;
                f.srcb = 1'b1;
            end
            7'h03: begin cls = 2; f.srcb = 1'b1; f.m2r = 2'd1; end
            7'h23: begin cls = 3; f.srcb = 1'b1; f.imm = 3'd1; end
            7'h63: begin
                cls = 0; f.alu = 4'd1; f.imm = 3'd2; f.branch = 1'b1; f.inv = (f3 == 3'd1);
            end
            7'h6F: begin f.imm = 3'd3; f.m2r = 2'd2; f.jump = 1'b1; end
            7'h67: begin f.srcb = 1'b1; f.m2r = 2'd2; f.jump = 1'b1; f.pcoff = 1'b1; end
            7'h37: begin f.imm = 3'd4; f.m2r = 2'd3; end
            default: begin f.imm = 3'd4; f.srcb = 1'b1; end
        endcase
    endtask

    task automatic run_illegal(input int fw);
        for (int k = 0; k <= fw + 1; k++) begin
            @(negedge clk);
            ifc32.mem_ready = (k <= fw) ? (k == fw) : 1'($urandom);
            ifc32.instr = (k > fw) ? 32'h0000007F : $urandom;
            #1;
            check_cycle("illegal_pre", {k <= fw, 1'b0, k == fw, 3'b000}, 1'b1, prev_f);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ifc32.mem_ready = 1'($urandom);
            ifc32.instr = $urandom;
            #1;
            check_cycle("illegal_sticky", 6'b000001, 1'b0, '0);
        end
        apply_reset();
    endtask

    task automatic reset_mid(input bit in_mem);
        int n;
        n = in_mem ? 4 : 2;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ifc32.mem_ready = in_mem && (k == 0);
            ifc32.instr = 32'h0040A283;
        end
        #1;
        chk(in_mem ? "mid_mem_req_before" : "mid_fetch_req_before", 64'(ifc32.mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk(in_mem ? "mid_mem_req_drop32" : "mid_fetch_req_drop32", 64'(ifc32.mem_req), 64'd0);
        chk(in_mem ? "mid_mem_req_drop4" : "mid_fetch_req_drop4", 64'(ifc4.mem_req), 64'd0);
        apply_reset();
    endtask

    vec_t vecs [21];

    initial begin
        int      cls, fw, mw;
        fields_t f;
        logic [31:0] ins;

        vecs[0]  = '{32'h002081B3, 0, 0, 1, mkf(0, 0, 0, 0, 0, 0, 0, 0)};  // ADD
        vecs[1]  = '{32'h0040A283, 2, 2, 2, mkf(0, 0, 1, 1, 0, 0, 0, 0)};  // LW, 2+2 waits
        vecs[2]  = '{32'h0020A423, 0, 0, 3, mkf(0, 1, 0, 1, 0, 0, 0, 0)};  // SW
        vecs[3]  = '{32'h00209463, 0, 0, 0, mkf(1, 2, 0, 0, 0, 1, 1, 0)};  // BNE
        vecs[4]  = '{32'h402081B3, 1, 0, 1, mkf(1, 0, 0, 0, 0, 0, 0, 0)};  // SUB
        vecs[5]  = '{32'h00208463, 0, 0, 0, mkf(1, 2, 0, 0, 0, 1, 0, 0)};  // BEQ
        vecs[6]  = '{32'h010000EF, 0, 0, 1, mkf(0, 3, 2, 0, 1, 0, 0, 0)};  // JAL
        vecs[7]  = '{32'h000100E7, 1, 0, 1, mkf(0, 0, 2, 1, 1, 0, 0, 1)};  // JALR
        vecs[8]  = '{32'h123452B7, 0, 0, 1, mkf(0, 4, 3, 0, 0, 0, 0, 0)};  // LUI
        vecs[9]  = '{32'h00001297, 0, 0, 1, mkf(0, 4, 0, 1, 0, 0, 0, 0)};  // AUIPC
        vecs[10] = '{32'h0050C193, 0, 0, 1, mkf(4, 0, 0, 1, 0, 0, 0, 0)};  // XORI
        vecs[11] = '{32'h4020D193, 0, 0, 1, mkf(7, 0, 0, 1, 0, 0, 0, 0)};  // SRAI
        vecs[12] = '{32'h0020B1B3, 0, 0, 1, mkf(9, 0, 0, 0, 0, 0, 0, 0)};  // SLTU
        vecs[13] = '{32'hC0008193, 0, 0, 1, mkf(0, 0, 0, 1, 0, 0, 0, 0)};  // ADDI, bit30 set
        vecs[14] = '{32'h0020A423, 1, 3, 3, mkf(0, 1, 0, 1, 0, 0, 0, 0)};  // SW with waits
        vecs[15] = '{32'h0040A283, 0, 0, 2, mkf(0, 0, 1, 1, 0, 0, 0, 0)};  // LW zero-wait
        vecs[16] = '{32'h0020F1B3, 0, 0, 1, mkf(2, 0, 0, 0, 0, 0, 0, 0)};  // AND
        vecs[17] = '{32'h0020E1B3, 0, 0, 1, mkf(3, 0, 0, 0, 0, 0, 0, 0)};  // OR
        vecs[18] = '{32'h002091B3, 0, 0, 1, mkf(5, 0, 0, 0, 0, 0, 0, 0)};  // SLL
        vecs[19] = '{32'h0020D1B3, 0, 0, 1, mkf(6, 0, 0, 0, 0, 0, 0, 0)};  // SRL
        vecs[20] = '{32'h0020A1B3, 0, 0, 1, mkf(8, 0, 0, 0, 0, 0, 0, 0)};  // SLT

        ifc32.instr = '0;
        ifc32.mem_ready = 1'b1;
        apply_reset();

        foreach (vecs[i]) run_insn(vecs[i].ins, vecs[i].fw, vecs[i].mw, vecs[i].cls, vecs[i].f);

        for (int i = 0; i < 60; i++) begin
            ins = rand_insn();
            ref_decode(ins, cls, f);
            fw = int'($urandom_range(3, 0));
            mw = int'($urandom_range(3, 0));
            run_insn(ins, fw, mw, cls, f);
        end

        reset_mid(1'b1);
        reset_mid(1'b0);

        for (int i = 0; i < 17; i++) run_insn(32'h002081B3, 0, 0, 1, mkf(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        ifc32.mem_ready = 1'b0;
        #1;
        chk("wrap_cnt4", 64'(ifc4.retired_count), 64'd1);
        chk("wrap_cnt32", 64'(ifc32.retired_count), 64'd17);

        run_illegal(int'($urandom_range(2, 0)));
        @(negedge clk);
        ifc32.mem_ready = 1'b1;
        #1;
        chk("post_illegal_clear", 64'(ifc32.illegal_insn), 64'd0);
        chk("post_illegal_req", 64'(ifc32.mem_req), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
